// File: rtl/lcm_pkt_dispatch_if.sv
// lcm_pkt_dispatch_if: 134-bit packet word stream with end-of-packet good/bad status.
interface lcm_pkt_dispatch_if;
   logic [133:0] data;
   logic         data_wr;
   logic         data_valid;
   logic         data_valid_wr;
   modport master (output data, data_wr, data_valid, data_valid_wr);
   modport slave  (input  data, data_wr, data_valid, data_valid_wr);
endinterface

// File: rtl/lcm_pkt_dispatch.sv
// lcm_pkt_dispatch: store-and-forward buffer releasing whole packets to lcm on pktin_ready.
// Define LCM_DISP_MAC_FILTER_EN to drop packets whose head DMAC is neither local nor broadcast.
module lcm_pkt_dispatch #(
   parameter int AW       = 6,
   parameter int MAX_PKTW = 12
) (
   input  logic                      clk,
   input  logic                      rst_n,
   lcm_pkt_dispatch_if.slave         um,
   lcm_pkt_dispatch_if.master        lcm,
   input  logic [47:0]               in_local_mac_id,
   input  logic                      pktin_ready,
   output logic [AW:0]               out_pkt_cnt,
   output logic [31:0]               out_drop_cnt
);
   localparam int          DEPTH    = 1 << AW;
   localparam logic [AW:0] USED_MAX = (AW+1)'(DEPTH - MAX_PKTW);
   localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE      = (AW+1)'(1);
   typedef enum logic {IDLE, SEND} state_t;

   // bit 134 marks the last word of a packet so the reader never relies on type bits alone
   logic [134:0] mem [DEPTH];
   logic [134:0] ram_q;
   logic [AW:0]  wp_t, wp_c, rp, base, wp_n;
   logic         in_pkt, drop_q, drop_n, mac_ok, start, cont, we, good, commit, abort, rd, tail_out;
   logic [1:0]   drop_inc;
   logic [32:0]  drop_sum;
   state_t       state, state_n;

`ifdef LCM_DISP_MAC_FILTER_EN
   assign mac_ok = um.data[127:80] == in_local_mac_id || &um.data[127:80];
`else
   logic unused_mac;
   assign unused_mac = ^in_local_mac_id;
   assign mac_ok = 1'b1;
`endif

   // a head always restarts at wp_c, which implicitly rolls back any unfinished packet
   always_comb begin
      start    = um.data_wr && um.data[133:132] == 2'b01;
      cont     = um.data_wr && um.data[133:132] != 2'b01;
      abort    = start && in_pkt;
      base     = start ? wp_c : wp_t;
      drop_n   = start ? (wp_c - rp > USED_MAX || !mac_ok)
               : cont ? (!in_pkt || drop_q || wp_t - rp == FULL) : drop_q;
      we       = um.data_wr && !drop_n;
      wp_n     = base + (AW+1)'(we);
      good     = um.data_valid && !drop_n;
      commit   = um.data_valid_wr && good;
      drop_inc = 2'(abort) + 2'(um.data_valid_wr && !good);
      drop_sum = {1'b0, out_drop_cnt} + 33'(drop_inc);
   end

   always_ff @(posedge clk)
      if (we) mem[base[AW-1:0]] <= {um.data_valid_wr, um.data};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp_t         <= '0;
         wp_c         <= '0;
         in_pkt       <= 1'b0;
         drop_q       <= 1'b0;
         out_drop_cnt <= '0;
      end else begin
         if (um.data_valid_wr) begin
            wp_t   <= commit ? wp_n : wp_c;
            if (commit) wp_c <= wp_n;
            in_pkt <= 1'b0;
            drop_q <= 1'b0;
         end else if (um.data_wr) begin
            wp_t   <= wp_n;
            in_pkt <= 1'b1;
            drop_q <= drop_n;
         end
         out_drop_cnt <= drop_sum[32] ? '1 : drop_sum[31:0];
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      if (state == IDLE && out_pkt_cnt != 0 && pktin_ready) state_n = SEND;
      else if (state == SEND && ram_q[134]) state_n = IDLE;
   end

   always_comb begin
      tail_out = state == SEND && ram_q[134];
      rd       = state == IDLE ? (out_pkt_cnt != 0 && pktin_ready) : !ram_q[134];
   end

   assign lcm.data_wr       = state == SEND;
   assign lcm.data          = state == SEND ? ram_q[133:0] : '0;
   assign lcm.data_valid_wr = tail_out;
   assign lcm.data_valid    = tail_out;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ram_q       <= '0;
         rp          <= '0;
         out_pkt_cnt <= '0;
      end else begin
         if (rd) begin
            ram_q <= mem[rp[AW-1:0]];
            rp    <= rp + ONE;
         end
         out_pkt_cnt <= out_pkt_cnt + (AW+1)'(commit) - (AW+1)'(tail_out);
      end
endmodule
